// File: rtl/scan_input_mux.sv
// Test-mode operand mux for an adder under test: selects functional pins or a
// scanned-in pattern, and captures the adder response into a scan chain.
module scan_input_mux #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           test_mode,
  input  logic           scan_en,
  input  logic           scan_in,
  input  logic           capture,
  input  logic [N-1:0]   pin_a,
  input  logic [N-1:0]   pin_b,
  input  logic           pin_cin,
  input  logic [N:0]     result,
  output logic [N-1:0]   sel_a,
  output logic [N-1:0]   sel_b,
  output logic           sel_cin,
  output logic           scan_out,
  output logic           pat_valid,
  output logic [1:0]     state,
  output logic           capt_err
);

  localparam int unsigned PAT_W   = 2 * N + 1;
  localparam int unsigned RSP_W   = N + 1;
  localparam int unsigned CHAIN_W = PAT_W + RSP_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAT_W);

  typedef enum logic [1:0] {
    ST_FUNC  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_APPLY = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [RSP_W-1:0]   rsp_q, rsp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pat_valid_q, pat_valid_d;
  logic               capt_err_q, capt_err_d;
  logic [N-1:0]       sel_a_q, sel_a_d;
  logic [N-1:0]       sel_b_q, sel_b_d;
  logic               sel_cin_q, sel_cin_d;
  logic               capt_req_c;
  logic               capt_ok_c;

  // Capture is only considered in test mode when the chain is not shifting.
  assign capt_req_c = test_mode & ~scan_en & capture;
  assign capt_ok_c  = capt_req_c & pat_valid_q;

  always_comb begin
    state_d     = ST_APPLY;
    pat_d       = pat_q;
    rsp_d       = rsp_q;
    cnt_d       = cnt_q;
    pat_valid_d = pat_valid_q;
    capt_err_d  = 1'b0;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    sel_cin_d   = sel_cin_q;

    if (!test_mode) begin
      state_d = ST_FUNC;
    end else if (scan_en) begin
      state_d = ST_SHIFT;
    end else if (capt_ok_c) begin
      state_d = ST_CAPT;
    end

    // Chain shifts toward RSP[0] whenever scan_en is high, even in functional mode.
    if (scan_en) begin
      {pat_d, rsp_d} = {scan_in, pat_q, rsp_q[RSP_W-1:1]};
    end else if (capt_ok_c) begin
      rsp_d = result;
    end

    if (!test_mode) begin
      cnt_d = '0;
    end else if (scan_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Flag rises on the same edge the counter reaches a full pattern.
    pat_valid_d = test_mode & (pat_valid_q | (cnt_d >= CNT_FULL));
    capt_err_d  = capt_req_c & ~pat_valid_q;

    if (!test_mode) begin
      sel_a_d   = pin_a;
      sel_b_d   = pin_b;
      sel_cin_d = pin_cin;
    end else if (!scan_en) begin
      sel_a_d   = pat_q[N:1];
      sel_b_d   = pat_q[2*N:N+1];
      sel_cin_d = pat_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FUNC;
      pat_q       <= '0;
      rsp_q       <= '0;
      cnt_q       <= '0;
      pat_valid_q <= 1'b0;
      capt_err_q  <= 1'b0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      sel_cin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      rsp_q       <= rsp_d;
      cnt_q       <= cnt_d;
      pat_valid_q <= pat_valid_d;
      capt_err_q  <= capt_err_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      sel_cin_q   <= sel_cin_d;
    end
  end

  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign sel_cin   = sel_cin_q;
  assign scan_out  = rsp_q[0];
  assign pat_valid = pat_valid_q;
  assign state     = state_q;
  assign capt_err  = capt_err_q;

endmodule

// File: tb/tb_scan_input_mux.sv
// Directed bench for scan_input_mux: vector table for mux/FSM behaviour plus
// hand-written scan load, capture, unload and reset sequences.
module tb_scan_input_mux;

  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          test_mode;
  logic          scan_en;
  logic          scan_in;
  logic          capture;
  logic [N-1:0]  pin_a;
  logic [N-1:0]  pin_b;
  logic          pin_cin;
  logic [N:0]    result;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;
  logic          sel_cin;
  logic          scan_out;
  logic          pat_valid;
  logic [1:0]    state;
  logic          capt_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  scan_input_mux #(.N(N), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .test_mode(test_mode), .scan_en(scan_en),
    .scan_in(scan_in), .capture(capture), .pin_a(pin_a), .pin_b(pin_b),
    .pin_cin(pin_cin), .result(result), .sel_a(sel_a), .sel_b(sel_b),
    .sel_cin(sel_cin), .scan_out(scan_out), .pat_valid(pat_valid),
    .state(state), .capt_err(capt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         tm;
    logic         se;
    logic         cap;
    logic [N-1:0] pa;
    logic [N-1:0] pb;
    logic         pc;
    logic [N-1:0] ea;
    logic [N-1:0] eb;
    logic         ec;
    logic [1:0]   est;
    logic         eerr;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; test_mode = 1'b0; scan_en = 1'b0; scan_in = 1'b0; capture = 1'b0;
    pin_a = '0; pin_b = '0; pin_cin = 1'b0; result = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    scan_en = 1'b1;
    scan_in = b;
    tick();
  endtask

  logic [3*N+1:0] pat;

  initial begin
    // Reset state
    do_reset();
    chk("rst_sel_a", 32'(sel_a), 32'h0);
    chk("rst_sel_b", 32'(sel_b), 32'h0);
    chk("rst_sel_cin", 32'(sel_cin), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_pat_valid", 32'(pat_valid), 32'h0);
    chk("rst_scan_out", 32'(scan_out), 32'h0);
    chk("rst_capt_err", 32'(capt_err), 32'h0);

    // Mux / FSM vector table, starting from the reset state (chain all zero)
    vt[0] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'hABCD, 1'b1, 16'h1234, 16'hABCD, 1'b1, 2'd0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 2'd0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 2'd0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 16'h7777, 16'h7777, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'd2, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h1111, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'd1, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 2'd0, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'd2, 1'b1};
    vt[7] = '{1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'd2, 1'b0};
    for (int i = 0; i < 8; i++) begin
      test_mode = vt[i].tm; scan_en = vt[i].se; capture = vt[i].cap; scan_in = 1'b0;
      pin_a = vt[i].pa; pin_b = vt[i].pb; pin_cin = vt[i].pc;
      tick();
      chk($sformatf("vec%0d_sel_a", i), 32'(sel_a), 32'(vt[i].ea));
      chk($sformatf("vec%0d_sel_b", i), 32'(sel_b), 32'(vt[i].eb));
      chk($sformatf("vec%0d_sel_cin", i), 32'(sel_cin), 32'(vt[i].ec));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].est));
      chk($sformatf("vec%0d_capt_err", i), 32'(capt_err), 32'(vt[i].eerr));
    end
    capture = 1'b0;

    // Full pattern load: b=FFFF, a=0000, cin=1, cin shifted first
    do_reset();
    pin_a = 16'h1234; pin_b = 16'hABCD; pin_cin = 1'b1;
    tick();
    test_mode = 1'b1;
    pat = '0;
    pat[2*N:0] = {16'hFFFF, 16'h0000, 1'b1};
    for (int k = 0; k < 2*N+1; k++) begin
      shift_bit(pat[k]);
      if (k == 0) chk("load_state_shift", 32'(state), 32'd1);
      if (k == 2*N-1) chk("load_pv_before_last", 32'(pat_valid), 32'h0);
    end
    chk("load_pv_after_33", 32'(pat_valid), 32'h1);
    chk("load_hold_a", 32'(sel_a), 32'h1234);
    chk("load_hold_b", 32'(sel_b), 32'hABCD);
    chk("load_hold_cin", 32'(sel_cin), 32'h1);
    scan_en = 1'b0;
    tick();
    chk("apply_sel_a", 32'(sel_a), 32'h0000);
    chk("apply_sel_b", 32'(sel_b), 32'hFFFF);
    chk("apply_sel_cin", 32'(sel_cin), 32'h1);
    chk("apply_state", 32'(state), 32'd2);

    // Capture result {cout=1,sum=0}, then unload; a capture during shift is ignored
    result = 17'h1_0000;
    capture = 1'b1;
    tick();
    chk("capt_state", 32'(state), 32'd3);
    chk("capt_no_err", 32'(capt_err), 32'h0);
    for (int i = 0; i <= N; i++) begin
      chk($sformatf("unload_bit%0d", i), 32'(scan_out), (i == N) ? 32'h1 : 32'h0);
      if (i < N) begin
        capture = (i == 5);
        result  = (i == 5) ? 17'h1_FFFF : 17'h1_0000;
        shift_bit(1'b0);
        if (i == 0) chk("unload_state", 32'(state), 32'd1);
        if (i == 5) begin
          chk("shift_cap_state", 32'(state), 32'd1);
          chk("shift_cap_no_err", 32'(capt_err), 32'h0);
        end
      end
    end
    capture = 1'b0;

    // Capture before a full pattern is rejected and leaves RSP alone
    do_reset();
    test_mode = 1'b1;
    for (int k = 0; k < 10; k++) shift_bit(1'b1);
    scan_en = 1'b0; capture = 1'b1; result = 17'h1_FFFF;
    tick();
    chk("early_capt_err", 32'(capt_err), 32'h1);
    chk("early_capt_state", 32'(state), 32'd2);
    chk("early_rsp_kept", 32'(scan_out), 32'h0);
    capture = 1'b0;
    tick();
    chk("early_err_pulse_end", 32'(capt_err), 32'h0);
    chk("early_state_apply", 32'(state), 32'd2);

    // Reset in the middle of a shift, then a full reload is required
    do_reset();
    test_mode = 1'b1;
    for (int k = 0; k < 20; k++) shift_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_sel_a", 32'(sel_a), 32'h0);
    chk("midrst_sel_b", 32'(sel_b), 32'h0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_pv", 32'(pat_valid), 32'h0);
    chk("midrst_scan_out", 32'(scan_out), 32'h0);
    for (int k = 0; k < 2*N+1; k++) begin
      shift_bit(1'b1);
      if (k == 0) chk("postrst_state", 32'(state), 32'd1);
      if (k == 2*N-1) chk("reload_pv_32", 32'(pat_valid), 32'h0);
    end
    chk("reload_pv_33", 32'(pat_valid), 32'h1);

    // Leaving test mode from SHIFT: pins selected, chain kept for the next test entry
    test_mode = 1'b0; scan_en = 1'b0;
    pin_a = 16'h5555; pin_b = 16'hAAAA; pin_cin = 1'b0;
    tick();
    chk("exit_state", 32'(state), 32'd0);
    chk("exit_sel_a", 32'(sel_a), 32'h5555);
    chk("exit_sel_b", 32'(sel_b), 32'hAAAA);
    chk("exit_pv", 32'(pat_valid), 32'h0);
    test_mode = 1'b1;
    tick();
    chk("reenter_sel_a", 32'(sel_a), 32'hFFFF);
    chk("reenter_sel_b", 32'(sel_b), 32'hFFFF);
    chk("reenter_sel_cin", 32'(sel_cin), 32'h1);
    chk("reenter_state", 32'(state), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_input_mux.md
SCAN_INPUT_MUX -- requirements
Module: scan_input_mux

Interface
REQ-001 Parameter N, default 16: operand width of a and b.
REQ-002 Parameter CNT_W, default 6: shift-counter width; SHALL satisfy 2^CNT_W > 3N+2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 test_mode  input  1  1 = operand outputs driven from scan pattern; 0 = from functional pins.
REQ-006 scan_en  input  1  1 = shift scan chain one bit per cycle.
REQ-007 scan_in  input  1  serial scan data into chain head.
REQ-008 capture  input  1  request to load result into response register.
REQ-009 pin_a, pin_b  input  N  functional operands.
REQ-010 pin_cin  input  1  functional carry-in.
REQ-011 result  input  N+1  adder response {cout, sum} to be captured.
REQ-012 sel_a, sel_b  output  N  registered selected operands.
REQ-013 sel_cin  output  1  registered selected carry-in.
REQ-014 scan_out  output  1  serial scan data from chain tail.
REQ-015 pat_valid  output  1  pattern register fully loaded since entering test mode.
REQ-016 state  output  2  FSM state: 0 FUNC, 1 SHIFT, 2 APPLY, 3 CAPT.
REQ-017 capt_err  output  1  one-cycle pulse: capture rejected.

Function
REQ-018 Scan chain SHALL be {PAT[2N:0], RSP[N:0]}, 3N+2 bits; PAT[0]=cin, PAT[N:1]=a, PAT[2N:N+1]=b.
REQ-019 Shift: scan_in enters PAT[2N], each bit moves one position toward RSP[0]; scan_out = RSP[0], straight from the flop.
REQ-020 Chain SHALL shift whenever scan_en=1, regardless of test_mode.
REQ-021 FSM next state: test_mode=0 -> FUNC; test_mode=1 and scan_en=1 -> SHIFT; test_mode=1, scan_en=0, capture=1, pat_valid=1 -> CAPT; else -> APPLY.
REQ-022 scan_en SHALL take priority over capture; capture with scan_en=1 is ignored, with no capt_err.
REQ-023 On entry to CAPT, RSP <= result; CAPT lasts one cycle, then per REQ-021.
REQ-024 capture=1 with test_mode=1, scan_en=0, pat_valid=0: RSP unchanged, next state APPLY, capt_err=1 for exactly the next cycle.
REQ-025 capture=1 with test_mode=0: ignored, no capt_err.
REQ-026 Shift counter cnt: cleared when test_mode=0; +1 per shift cycle in test mode; saturates at 3N+2.
REQ-027 pat_valid SHALL be a registered flag: set once cnt reaches 2N+1, cleared when test_mode=0.
REQ-028 Output mux, 1-cycle latency:
- test_mode=0: sel_a/sel_b/sel_cin <= pin_a/pin_b/pin_cin.
- test_mode=1, scan_en=1: outputs hold their previous value (no ripple during shift).
- test_mode=1, scan_en=0: outputs <= PAT fields.
REQ-029 test_mode falling while in SHIFT: the next cycle goes to FUNC; chain contents are kept; outputs take the pins one cycle later.
REQ-030 Outputs change only on clock edges; no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 at an edge: PAT, RSP, cnt, sel_a, sel_b, sel_cin, scan_out, pat_valid, capt_err = 0; state = FUNC.
REQ-032 rst SHALL override every other input in the same cycle, including mid-shift and during CAPT.
REQ-033 After rst deasserts, the first edge evaluates per REQ-021 from FUNC.

Verification (N=16)
REQ-034 test_mode=0, pin_a=16'h1234, pin_b=16'hABCD, pin_cin=1 -> one edge later sel_a=1234, sel_b=ABCD, sel_cin=1, state=0.
REQ-035 test_mode=1, shift 33 bits encoding b=FFFF, a=0000, cin=1 (cin bit first); scan_en=0 -> sel_* stay at old values during shift; pat_valid=1 after 33rd shift; next edge sel_a=0000, sel_b=FFFF, sel_cin=1, state=2.
REQ-036 After REQ-035, result=17'h1_0000, capture=1 for one cycle -> state=3 for one cycle; then 17 shifts -> scan_out returns 0 x16 followed by 1.
REQ-037 Fresh test_mode=1, 10 shifts, then capture=1 -> capt_err pulses one cycle, RSP unchanged, state=2.
REQ-038 Mid-shift (bit 20 of 33), rst=1 for one cycle -> all outputs 0, state=0, pat_valid=0; reload needs a full 33 shifts.
REQ-039 scan_en=1 and capture=1 together in test mode -> shift only, RSP not loaded, capt_err=0.
